// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI-Lite initiator behind a simple command/response port
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [15:0]           err_count,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP
);
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
  state_t state, state_n;
  logic cmd_ready_n, awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n, rsp_valid_n, rsp_write_n;
  logic [ADDR_WIDTH-1:0] awaddr_n, araddr_n;
  logic [DATA_WIDTH-1:0] wdata_n, rsp_rdata_n;
  logic [1:0] rsp_resp_n;
  logic [15:0] err_count_n;
  logic capture;
  // next-state and next-output values; every output is a register fed from here
  always_comb begin
    state_n = state;
    cmd_ready_n = cmd_ready;
    awvalid_n = AWVALID;
    wvalid_n = WVALID;
    bready_n = BREADY;
    arvalid_n = ARVALID;
    rready_n = RREADY;
    rsp_valid_n = rsp_valid;
    rsp_write_n = rsp_write;
    awaddr_n = AWADDR;
    wdata_n = WDATA;
    araddr_n = ARADDR;
    rsp_rdata_n = rsp_rdata;
    rsp_resp_n = rsp_resp;
    capture = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_n = !(cmd_valid && cmd_ready);
        if (cmd_valid && cmd_ready) begin
          state_n = cmd_write ? WR_AW_W : RD_AR;
          awvalid_n = cmd_write;
          wvalid_n = cmd_write;
          arvalid_n = !cmd_write;
          awaddr_n = cmd_write ? cmd_addr : AWADDR;
          wdata_n = cmd_write ? cmd_wdata : WDATA;
          araddr_n = cmd_write ? ARADDR : cmd_addr;
        end
      end
      WR_AW_W: begin
        awvalid_n = AWVALID && !AWREADY;
        wvalid_n = WVALID && !WREADY;
        if (!awvalid_n && !wvalid_n) begin
          state_n = WR_B;
          bready_n = 1'b1;
        end
      end
      WR_B: if (BVALID && BREADY) begin
        state_n = RSP;
        bready_n = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_write_n = 1'b1;
        rsp_rdata_n = '0;
        rsp_resp_n = BRESP;
        capture = 1'b1;
      end
      RD_AR: if (ARREADY) begin
        state_n = RD_R;
        arvalid_n = 1'b0;
        rready_n = 1'b1;
      end
      RD_R: if (RVALID && RREADY) begin
        state_n = RSP;
        rready_n = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_write_n = 1'b0;
        rsp_rdata_n = RDATA;
        rsp_resp_n = RRESP;
        capture = 1'b1;
      end
      RSP: if (rsp_ready) begin
        state_n = IDLE;
        rsp_valid_n = 1'b0;
        cmd_ready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    err_count_n = (capture && rsp_resp_n != 2'b00 && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
  end
  // state and output registers; reset drops any in-flight transaction
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      AWVALID <= 1'b0;
      WVALID <= 1'b0;
      BREADY <= 1'b0;
      ARVALID <= 1'b0;
      RREADY <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      AWADDR <= '0;
      WDATA <= '0;
      ARADDR <= '0;
      rsp_rdata <= '0;
      rsp_resp <= 2'b00;
      err_count <= 16'd0;
    end else begin
      state <= state_n;
      cmd_ready <= cmd_ready_n;
      AWVALID <= awvalid_n;
      WVALID <= wvalid_n;
      BREADY <= bready_n;
      ARVALID <= arvalid_n;
      RREADY <= rready_n;
      rsp_valid <= rsp_valid_n;
      rsp_write <= rsp_write_n;
      AWADDR <= awaddr_n;
      WDATA <= wdata_n;
      ARADDR <= araddr_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_resp <= rsp_resp_n;
      err_count <= err_count_n;
    end
endmodule
